// File: rtl/div_bcd_converter.sv
// Binary-to-BCD converter built around an external iterative divider: each
// divide-by-10 remainder becomes one BCD digit, units digit first.
module div_bcd_converter #(
    parameter int BITSIZE = 16,
    parameter int DIGITS  = 5,
    parameter int CNTSIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITSIZE-1:0]    in_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [CNTSIZE-1:0]    ndigits,
    output logic                  ovf,
    output logic                  digit_err,
    output logic                  div_strt,
    output logic [BITSIZE-1:0]    div_dividend,
    output logic [BITSIZE-1:0]    div_divisor,
    input  logic [BITSIZE-1:0]    div_quotient,
    input  logic [BITSIZE-1:0]    div_remainder,
    input  logic                  div_idle
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_BUSY   = 3'd2,
        S_DONE   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [BITSIZE-1:0] DIVISOR  = BITSIZE'(10);
    localparam logic [CNTSIZE-1:0] LAST_IDX = CNTSIZE'(DIGITS - 1);

    state_t                state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  div_strt_q,  div_strt_d;
    logic [4*DIGITS-1:0]   bcd_q,       bcd_d;
    logic [CNTSIZE-1:0]    ndigits_q,   ndigits_d;
    logic                  ovf_q,       ovf_d;
    logic                  digit_err_q, digit_err_d;
    logic [BITSIZE-1:0]    dividend_q,  dividend_d;
    logic [BITSIZE-1:0]    work_q,      work_d;
    logic [CNTSIZE-1:0]    idx_q,       idx_d;

    // Next-state and next-output computation for the conversion sequencer.
    always_comb begin
        state_d     = state_q;
        div_strt_d  = 1'b0;
        bcd_d       = bcd_q;
        ndigits_d   = ndigits_q;
        ovf_d       = ovf_q;
        digit_err_d = digit_err_q;
        dividend_d  = dividend_q;
        work_d      = work_q;
        idx_d       = idx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d      = in_value;
                    dividend_d  = in_value;
                    bcd_d       = '0;
                    ovf_d       = 1'b0;
                    digit_err_d = 1'b0;
                    idx_d       = '0;
                    state_d     = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (div_idle) begin
                    div_strt_d = 1'b1;
                    state_d    = S_BUSY;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_BUSY: begin
                // Divider has taken the start once it drops idle.
                if (!div_idle) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (div_idle) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (idx_q == CNTSIZE'(k)) begin
                            bcd_d[4*k +: 4] = div_remainder[3:0];
                        end else begin
                            bcd_d[4*k +: 4] = bcd_q[4*k +: 4];
                        end
                    end
                    digit_err_d = digit_err_q | (div_remainder >= DIVISOR);
                    work_d      = div_quotient;
                    dividend_d  = div_quotient;
                    ndigits_d   = idx_q + CNTSIZE'(1);
                    idx_d       = idx_q + CNTSIZE'(1);
                    if (div_quotient == BITSIZE'(0)) begin
                        state_d = S_OUT;
                    end else if (idx_q == LAST_IDX) begin
                        ovf_d   = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    // State and registered-output flops; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_strt_q  <= 1'b0;
            bcd_q       <= '0;
            ndigits_q   <= '0;
            ovf_q       <= 1'b0;
            digit_err_q <= 1'b0;
            dividend_q  <= '0;
            work_q      <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            div_strt_q  <= div_strt_d;
            bcd_q       <= bcd_d;
            ndigits_q   <= ndigits_d;
            ovf_q       <= ovf_d;
            digit_err_q <= digit_err_d;
            dividend_q  <= dividend_d;
            work_q      <= work_d;
            idx_q       <= idx_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign div_strt     = div_strt_q;
    assign bcd          = bcd_q;
    assign ndigits      = ndigits_q;
    assign ovf          = ovf_q;
    assign digit_err    = digit_err_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = DIVISOR;

endmodule
